alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: accepts one ALU request at a time, holds the operands and
// opcode stable for the external combinational ALU, lets the ALU settle, then
// captures its two result halves into a response register.
// Requests with an opcode above MAX_OPCODE skip the ALU. They answer at once
// with rsp_err set and a zero result.
//
// Ports:
//   clock                 rising-edge clock
//   clear                 asynchronous active-high reset
//   req_valid/req_ready   request handshake; req_ready is high only in IDLE
//   req_a, req_b          32-bit operands
//   req_opcode            5-bit ALU operation select
//   alu_a, alu_b          registered operands driven to the ALU
//   alu_opcode            registered opcode driven to the ALU
//   alu_zlow, alu_zhigh   ALU result halves
//   rsp_valid/rsp_ready   response handshake; rsp_valid is high only in RESP
//   rsp_zlow, rsp_zhigh   captured result
//   rsp_err               response belongs to an illegal opcode
//   op_count              completed legal operations, wraps modulo 2^16
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_OPCODE    = 11
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_opcode,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [31:0] alu_zlow,
  input  logic [31:0] alu_zhigh,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_zlow,
  output logic [31:0] rsp_zhigh,
  output logic        rsp_err,
  output logic [15:0] op_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    EXEC    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [4:0] MAX_OP      = 5'(MAX_OPCODE);
  // EXEC leaves when the counter reads zero, so it starts at SETTLE_CYCLES-1
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_r;
  state_t      state_next_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_next_s;
  logic        accept_s;
  logic        legal_s;
  logic        capture_s;

  logic [31:0] alu_a_r;
  logic [31:0] alu_b_r;
  logic [4:0]  alu_opcode_r;
  logic [31:0] rsp_zlow_r;
  logic [31:0] rsp_zhigh_r;
  logic        rsp_err_r;
  logic [15:0] op_count_r;

  // Next-state, settle counter and datapath strobes
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    legal_s      = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          if (req_opcode <= MAX_OP) begin
            legal_s      = 1'b1;
            state_next_s = LOAD;
          end else begin
            state_next_s = RESP;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      LOAD: begin
        cnt_next_s   = SETTLE_LOAD;
        state_next_s = EXEC;
      end
      EXEC: begin
        if (cnt_r == 4'd0) begin
          state_next_s = CAPTURE;
        end else begin
          cnt_next_s   = cnt_r - 4'd1;
          state_next_s = EXEC;
        end
      end
      CAPTURE: begin
        capture_s    = 1'b1;
        state_next_s = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // State and settle counter registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // ALU operand, response and operation-count registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      alu_a_r      <= 32'd0;
      alu_b_r      <= 32'd0;
      alu_opcode_r <= 5'd0;
      rsp_zlow_r   <= 32'd0;
      rsp_zhigh_r  <= 32'd0;
      rsp_err_r    <= 1'b0;
      op_count_r   <= 16'd0;
    end else begin
      if (accept_s && legal_s) begin
        alu_a_r      <= req_a;
        alu_b_r      <= req_b;
        alu_opcode_r <= req_opcode;
      end
      if (accept_s && !legal_s) begin
        // illegal opcode: the ALU operands keep their previous values
        rsp_zlow_r  <= 32'd0;
        rsp_zhigh_r <= 32'd0;
        rsp_err_r   <= 1'b1;
      end else if (capture_s) begin
        rsp_zlow_r  <= alu_zlow;
        rsp_zhigh_r <= alu_zhigh;
        rsp_err_r   <= 1'b0;
        op_count_r  <= op_count_r + 16'd1;
      end
    end
  end

  // Handshake flags are decoded from the state register only
  assign req_ready  = (state_r == IDLE);
  assign rsp_valid  = (state_r == RESP);
  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_opcode = alu_opcode_r;
  assign rsp_zlow   = rsp_zlow_r;
  assign rsp_zhigh  = rsp_zhigh_r;
  assign rsp_err    = rsp_err_r;
  assign op_count   = op_count_r;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. A stub ALU returns zlow=a+b, zhigh=a^b.
// Inputs change and outputs are sampled 1 time unit after a rising edge.
module tb_alu_sequencer;

  logic        clock;
  logic        clear;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_opcode;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_zlow;
  logic [31:0] alu_zhigh;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_zlow;
  logic [31:0] rsp_zhigh;
  logic        rsp_err;
  logic [15:0] op_count;

  int pass_count = 0;
  int check_count = 0;

  alu_sequencer #(.SETTLE_CYCLES(2), .MAX_OPCODE(11)) dut (
    .clock(clock), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_zlow(alu_zlow), .alu_zhigh(alu_zhigh),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_zlow(rsp_zlow), .rsp_zhigh(rsp_zhigh), .rsp_err(rsp_err),
    .op_count(op_count)
  );

  assign alu_zlow  = alu_a + alu_b;
  assign alu_zhigh = alu_a ^ alu_b;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Present a request once req_ready is high; returns 1 time unit after the accepting edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    int waited;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    req_a = a; req_b = b; req_opcode = op; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  // Count edges after acceptance until rsp_valid; optionally scramble request inputs meanwhile
  task automatic wait_rsp(input bit toggle, output int edges);
    edges = 0;
    while (rsp_valid !== 1'b1 && edges < 40) begin
      if (toggle) begin
        req_a = $urandom; req_b = $urandom; req_opcode = 5'($urandom); req_valid = 1'b1;
      end
      @(posedge clock); #1;
      edges++;
    end
    req_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_a = 32'd0; req_b = 32'd0; req_opcode = 5'd0;
    #12;
    check_count++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b want 1", req_ready); else pass_count++;
    check_count++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else pass_count++;
    check_count++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_opcode !== 5'd0) $display("FAIL reset_alu got %h %h %h want 0", alu_a, alu_b, alu_opcode); else pass_count++;
    check_count++; if (rsp_zlow !== 32'd0 || rsp_zhigh !== 32'd0 || rsp_err !== 1'b0) $display("FAIL reset_rsp got %h %h %b want 0", rsp_zlow, rsp_zhigh, rsp_err); else pass_count++;
    check_count++; if (op_count !== 16'd0) $display("FAIL reset_op_count got %h want 0", op_count); else pass_count++;
    @(negedge clock);
    clear = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_legal();
    int e;
    issue(32'hFFFF_FFF9, 32'd10, 5'd0);
    wait_rsp(1'b0, e);
    check_count++; if (e !== 4) $display("FAIL legal_latency got %0d want 4", e); else pass_count++;
    check_count++; if (rsp_zlow !== 32'h0000_0003) $display("FAIL legal_zlow got %h want 00000003", rsp_zlow); else pass_count++;
    check_count++; if (rsp_zhigh !== 32'hFFFF_FFF3) $display("FAIL legal_zhigh got %h want fffffff3", rsp_zhigh); else pass_count++;
    check_count++; if (rsp_err !== 1'b0) $display("FAIL legal_err got %b want 0", rsp_err); else pass_count++;
    check_count++; if (op_count !== 16'd1) $display("FAIL legal_op_count got %h want 1", op_count); else pass_count++;
    consume();
    check_count++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL legal_return_idle got valid=%b ready=%b want 0 1", rsp_valid, req_ready); else pass_count++;
    check_count++; if (rsp_zlow !== 32'h0000_0003) $display("FAIL legal_zlow_hold got %h want 00000003", rsp_zlow); else pass_count++;
  endtask

  task automatic test_illegal();
    int e;
    issue(32'd1, 32'd2, 5'd12);
    wait_rsp(1'b0, e);
    check_count++; if (e !== 0) $display("FAIL illegal_latency got %0d want 0", e); else pass_count++;
    check_count++; if (rsp_err !== 1'b1) $display("FAIL illegal_err got %b want 1", rsp_err); else pass_count++;
    check_count++; if (rsp_zlow !== 32'd0 || rsp_zhigh !== 32'd0) $display("FAIL illegal_z got %h %h want 0 0", rsp_zlow, rsp_zhigh); else pass_count++;
    check_count++; if (op_count !== 16'd1) $display("FAIL illegal_op_count got %h want 1", op_count); else pass_count++;
    check_count++; if (alu_a !== 32'hFFFF_FFF9 || alu_b !== 32'd10 || alu_opcode !== 5'd0) $display("FAIL illegal_alu_kept got %h %h %h want fffffff9 a 0", alu_a, alu_b, alu_opcode); else pass_count++;
    consume();
  endtask

  task automatic test_backpressure();
    int e;
    issue(32'h0000_03FF, 32'h0000_02AA, 5'd1);
    wait_rsp(1'b0, e);
    check_count++; if (e !== 4) $display("FAIL bp_latency got %0d want 4", e); else pass_count++;
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_a = 32'hDEAD_BEEF; req_b = 32'h1234_0000; req_opcode = 5'd2;
      @(posedge clock); #1;
      check_count++; if (rsp_valid !== 1'b1 || req_ready !== 1'b0) $display("FAIL bp_hold_flags cycle %0d got valid=%b ready=%b want 1 0", i, rsp_valid, req_ready); else pass_count++;
      check_count++; if (rsp_zlow !== 32'h0000_06A9 || alu_a !== 32'h0000_03FF) $display("FAIL bp_hold_data cycle %0d got zlow=%h alu_a=%h want 6a9 3ff", i, rsp_zlow, alu_a); else pass_count++;
    end
    req_valid = 1'b0;
    check_count++; if (op_count !== 16'd2) $display("FAIL bp_op_count got %h want 2", op_count); else pass_count++;
    consume();
    check_count++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_release got valid=%b ready=%b want 0 1", rsp_valid, req_ready); else pass_count++;
  endtask

  task automatic test_clear_exec();
    int e;
    issue(32'd7, 32'd8, 5'd0);
    @(posedge clock); #1;
    #2 clear = 1'b1;
    #1;
    check_count++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_opcode !== 5'd0) $display("FAIL clear_alu got %h %h %h want 0", alu_a, alu_b, alu_opcode); else pass_count++;
    check_count++; if (rsp_zlow !== 32'd0 || rsp_zhigh !== 32'd0 || rsp_err !== 1'b0 || op_count !== 16'd0) $display("FAIL clear_rsp got %h %h %b %h want 0", rsp_zlow, rsp_zhigh, rsp_err, op_count); else pass_count++;
    check_count++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL clear_flags got valid=%b ready=%b want 0 1", rsp_valid, req_ready); else pass_count++;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_count++; if (rsp_valid !== 1'b0) $display("FAIL clear_no_rsp got %b want 0", rsp_valid); else pass_count++;
    @(negedge clock);
    clear = 1'b0;
    req_a = 32'd5; req_b = 32'd5; req_opcode = 5'd0; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check_count++; if (req_ready !== 1'b0 || alu_a !== 32'd5) $display("FAIL clear_first_edge_accept got ready=%b alu_a=%h want 0 5", req_ready, alu_a); else pass_count++;
    wait_rsp(1'b0, e);
    check_count++; if (e !== 4 || rsp_zlow !== 32'd10) $display("FAIL clear_next_req got edges=%0d zlow=%h want 4 a", e, rsp_zlow); else pass_count++;
    check_count++; if (op_count !== 16'd1) $display("FAIL clear_op_count got %h want 1", op_count); else pass_count++;
    consume();
  endtask

  task automatic test_wrap();
    int e;
    force dut.op_count_r = 16'hFFFF;
    @(posedge clock); #1;
    release dut.op_count_r;
    check_count++; if (op_count !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", op_count); else pass_count++;
    issue(32'd1, 32'd1, 5'd11);
    wait_rsp(1'b0, e);
    check_count++; if (op_count !== 16'h0000) $display("FAIL wrap_op_count got %h want 0000", op_count); else pass_count++;
    check_count++; if (rsp_zlow !== 32'd2 || rsp_err !== 1'b0) $display("FAIL wrap_max_opcode got zlow=%h err=%b want 2 0", rsp_zlow, rsp_err); else pass_count++;
    consume();
  endtask

  task automatic test_toggle();
    int e;
    issue(32'h1234_5678, 32'h1111_1111, 5'd3);
    wait_rsp(1'b1, e);
    check_count++; if (e !== 4) $display("FAIL toggle_latency got %0d want 4", e); else pass_count++;
    check_count++; if (alu_a !== 32'h1234_5678 || alu_b !== 32'h1111_1111 || alu_opcode !== 5'd3) $display("FAIL toggle_alu_stable got %h %h %h want 12345678 11111111 3", alu_a, alu_b, alu_opcode); else pass_count++;
    check_count++; if (rsp_zlow !== 32'h2345_6789 || rsp_zhigh !== 32'h0325_4769) $display("FAIL toggle_result got %h %h want 23456789 03254769", rsp_zlow, rsp_zhigh); else pass_count++;
    check_count++; if (op_count !== 16'd1) $display("FAIL toggle_op_count got %h want 1", op_count); else pass_count++;
    consume();
  endtask

  initial begin
    test_reset();
    test_legal();
    test_illegal();
    test_backpressure();
    test_clear_exec();
    test_wrap();
    test_toggle();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d so far", pass_count, check_count);
    $fatal(1);
  end

endmodule
